// File: rtl/div_iter.sv
// Iterative radix-2 restoring divider for the EXE stage.
// Decodes div.w / mod.w / div.wu / mod.wu from mul_div_op and returns the
// quotient or remainder after ITER iteration cycles via a valid/ready handshake.
`timescale 1ns/1ps
module div_iter #(
   parameter int WIDTH = 32,
   parameter int ITER  = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [9:0]       mul_div_op,
   input  logic [WIDTH-1:0] alu_src1,
   input  logic [WIDTH-1:0] alu_src2,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] div_result
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t           state_reg, state_next;
   logic [CW-1:0]    cnt_reg;
   logic [WIDTH-1:0] rem_reg;     // partial remainder
   logic [WIDTH-1:0] quo_reg;     // dividend bits shifting out, quotient bits shifting in
   logic [WIDTH-1:0] dvs_reg;     // divisor magnitude
   logic [WIDTH-1:0] result_reg;
   logic             is_mod_reg, neg_q_reg, neg_r_reg, dbz_reg;

   // Request decode; only op[6:3] belong to the divider
   logic             is_div_op, accept, is_signed, is_mod, neg1, neg2;
   logic [WIDTH-1:0] mag1, mag2;

   assign is_div_op = |mul_div_op[6:3];
   assign accept    = in_valid & in_ready & is_div_op & ~flush;
   assign is_signed = mul_div_op[3] | mul_div_op[4];
   assign is_mod    = mul_div_op[4] | mul_div_op[6];
   assign neg1      = is_signed & alu_src1[WIDTH-1];
   assign neg2      = is_signed & alu_src2[WIDTH-1];
   // |0x80000000| wraps back to 0x80000000, which is correct as an unsigned magnitude
   assign mag1      = neg1 ? -alu_src1 : alu_src1;
   assign mag2      = neg2 ? -alu_src2 : alu_src2;

   // One restoring step: shift {rem, dividend} left, trial-subtract the divisor.
   // The top bit of trial is the borrow of the 33-bit subtraction.
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] trial;
   logic             trial_ok, last;
   logic [WIDTH-1:0] rem_new, quo_new, q_final, r_final, fixed;

   assign shifted  = {rem_reg, quo_reg[WIDTH-1]};
   assign trial    = {1'b0, shifted} - {2'b00, dvs_reg};
   assign trial_ok = ~trial[WIDTH+1];
   // A successful trial always leaves a difference below the divisor, so it fits WIDTH bits
   assign rem_new  = trial_ok ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
   assign quo_new  = {quo_reg[WIDTH-2:0], trial_ok};
   assign last     = (cnt_reg == CW'(ITER - 1));

   // Sign fix-up. With a zero divisor every trial succeeds, so the remainder
   // ends up as |src1| and its fix-up restores src1 exactly; only the quotient
   // needs forcing to all ones.
   assign q_final  = dbz_reg ? '1 : (neg_q_reg ? -quo_new : quo_new);
   assign r_final  = neg_r_reg ? -rem_new : rem_new;
   assign fixed    = is_mod_reg ? r_final : q_final;

   // Bits that are deliberately not consumed
   logic unused_bits;
   assign unused_bits = &{1'b0, mul_div_op[2:0], mul_div_op[9:7], trial[WIDTH]};

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_reg <= IDLE;
      else         state_reg <= state_next;
   end

   // Next-state logic; flush overrides every transition
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept)    state_next = CALC;
         CALC:    if (last)      state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default:                state_next = IDLE;
      endcase
      if (flush) state_next = IDLE;
   end

   // Datapath: latch operands on accept, iterate in CALC, capture result on the last step
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_reg    <= '0;
         rem_reg    <= '0;
         quo_reg    <= '0;
         dvs_reg    <= '0;
         result_reg <= '0;
         is_mod_reg <= 1'b0;
         neg_q_reg  <= 1'b0;
         neg_r_reg  <= 1'b0;
         dbz_reg    <= 1'b0;
      end else if (accept) begin
         cnt_reg    <= '0;
         rem_reg    <= '0;
         quo_reg    <= mag1;
         dvs_reg    <= mag2;
         result_reg <= '0;
         is_mod_reg <= is_mod;
         neg_q_reg  <= neg1 ^ neg2;
         neg_r_reg  <= neg1;
         dbz_reg    <= (alu_src2 == '0);
      end else if (state_reg == CALC && !flush) begin
         cnt_reg <= cnt_reg + 1'b1;
         rem_reg <= rem_new;
         quo_reg <= quo_new;
         if (last) result_reg <= fixed;
      end
   end

   // Outputs decode directly from state so reset takes effect immediately
   assign in_ready   = (state_reg == IDLE);
   assign out_valid  = (state_reg == DONE);
   assign div_result = out_valid ? result_reg : '0;

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 integer divider in the EXE stage, alongside the single-cycle multiplier.
- Decodes the divide bits of the shared 10-bit mul_div_op bus: div.w, mod.w, div.wu and mod.wu.
- Runs for 32 cycles and returns the result to the EXE result mux through a valid/ready handshake.
- EXE stalls on in_ready/out_valid while a divide is in flight.

Parameters:
- WIDTH, 32, operand and result width. Only 32 is supported.
- ITER, 32, number of iteration cycles. Must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- resetn  in  1  asynchronous active-low reset.
- in_valid  in  1  EXE presents a divide request.
- in_ready  out  1  divider can accept a request (state IDLE).
- mul_div_op  in  10  op bits: [3] div.w, [4] mod.w, [5] div.wu, [6] mod.wu. Bits [2:0] are multiply ops and bits [9:7] are reserved; the divider ignores all of them.
- alu_src1  in  32  dividend.
- alu_src2  in  32  divisor.
- flush  in  1  pipeline flush (exception/ertn); aborts any divide.
- out_valid  out  1  div_result is valid.
- out_ready  in  1  EXE consumes the result.
- div_result  out  32  quotient or remainder.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, in_ready=1, out_valid=0, div_result=0.
  - All internal registers are cleared.
  - Reset in the middle of an operation discards it with no result.
- States:
  - IDLE -> CALC: on in_valid & in_ready & any of op[6:3] & !flush.
  - CALC -> DONE: when iteration counter = ITER-1.
  - DONE -> IDLE: on out_ready.
  - Any state -> IDLE: on flush.
- Request filtering: in_valid with op[6:3]=0 is ignored. The divider stays in IDLE and never raises out_valid for it.
- Exactly one of op[6:3] is set per request. The op, signs and operands are latched at accept; later input changes have no effect.
- Signed ops (op[3], op[4]):
  - Operate on magnitudes |src1|, |src2|. |0x80000000| = 0x80000000 as unsigned.
  - Quotient sign = sign1 XOR sign2; remainder sign = sign1.
  - Fix-up is two's-complement negation on the final cycle.
- Unsigned ops (op[5], op[6]): no sign handling.
- Iteration (restoring division), one quotient bit per CALC cycle, MSB first:
  - Shift {rem, dividend} left by one.
  - Trial-subtract the divisor using a 33-bit subtractor.
  - If the subtraction is non-negative, set the quotient bit and keep the difference.
- Divide by zero (src2=0), signed or unsigned: quotient = 0xFFFFFFFF and remainder = src1 unchanged. No sign fix-up is applied.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0. Falls out of the magnitude algorithm naturally.
- Latency:
  - Accept in cycle T; CALC occupies T+1..T+32.
  - out_valid=1 from cycle T+33 and is held, together with a stable div_result, until out_ready.
  - in_ready=0 from T+1 until the cycle after the handshake.
- Back-to-back: the handshake cycle returns to IDLE. A new request can be accepted the following cycle; no same-cycle accept in DONE.
- Flush:
  - Synchronous and highest priority; beats a simultaneous accept or out handshake.
  - Next cycle: state IDLE, out_valid=0, in_ready=1. The partial result is discarded.
  - A flush arriving together with in_valid in IDLE is not accepted.
- div_result is 0 whenever out_valid=0.

Test Plan:
- div.w 0xFFFFFFF9 (-7) / 2, out_ready=1 -> out_valid exactly 33 cycles after accept, div_result=0xFFFFFFFD. mod.w same operands -> 0xFFFFFFFF. mod.w 7 / 0xFFFFFFFE -> 0x00000001.
- div.wu 0xFFFFFFFF / 3 -> 0x55555555. mod.wu 100 / 7 -> 0x00000002.
- Divide by zero: div.wu 7/0 -> 0xFFFFFFFF; mod.wu 7/0 -> 0x00000007; div.w 0xFFFFFFF9/0 -> 0xFFFFFFFF; mod.w 0xFFFFFFF9/0 -> 0xFFFFFFF9.
- Overflow: div.w 0x80000000 / 0xFFFFFFFF -> 0x80000000; mod.w -> 0x00000000.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid -> out_valid and div_result stable, in_ready=0.
  - Change alu_src1/alu_src2 during CALC -> result unaffected.
  - A second request issued on the cycle after the handshake is accepted.
- Flush and reset:
  - Flush at CALC cycle 15 -> out_valid never rises; in_ready=1 on the next cycle; a new div.wu 10/3 then yields 0x00000003.
  - Assert resetn=0 mid-CALC -> outputs go to reset values immediately, asynchronously.
  - in_valid with mul_div_op=0x001 (multiply only) -> ignored, in_ready stays 1.
